z80_im2_irq_ctrl: RTL and testbench

- Interrupt responder for a Z80 (tv80s) running in interrupt mode 2.
- Collects up to NUM_SRC falling-edge interrupt sources (VBL, sound CPU, MCU, timer) and drives the CPU int_n line.
- Answers the CPU's interrupt-acknowledge cycle (M1 and IORQ both asserted) by presenting the mode-2 vector byte on a dedicated data path that the CPU data mux selects while vec_oe is high.
- Replaces hard-coded vector patching inside CPU wrappers with a prioritised, per-source vector.

---
 rtl/z80_im2_irq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_z80_im2_irq_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_im2_irq_ctrl.sv
// z80_im2_irq_ctrl: Z80 interrupt-mode-2 responder.
// Latches falling-edge requests from up to NUM_SRC sources and drives int_n.
// On an acknowledge cycle (M1 and IORQ), it presents the vector of the
// lowest-index enabled pending source on a dedicated byte path.
module z80_im2_irq_ctrl #(
    parameter int unsigned NUM_SRC    = 4,
    parameter logic [7:0]  VEC_BASE   = 8'h92,
    parameter int unsigned VEC_STRIDE = 2,
    parameter logic [7:0]  SPUR_VEC   = 8'hFF
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_n,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic [NUM_SRC-1:0] clr_pend,
    input  logic               cpu_m1,
    input  logic               cpu_io,
    output logic               int_n,
    output logic [7:0]         vec_dout,
    output logic               vec_oe,
    output logic [NUM_SRC-1:0] pending,
    output logic [2:0]         ack_src
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Vector byte for a source index; the sum wraps modulo 256.
    function automatic logic [7:0] src_vec(input logic [2:0] idx);
        logic [15:0] prod;
        prod = 16'(idx) * 16'(VEC_STRIDE);
        return VEC_BASE + prod[7:0];
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [NUM_SRC-1:0] irq_cur_r;
    logic [NUM_SRC-1:0] irq_prev_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] pending_nxt_s;
    logic [NUM_SRC-1:0] fall_s;
    logic [NUM_SRC-1:0] cand_s;
    logic [NUM_SRC-1:0] ack_clr_s;
    logic               req_s;
    logic               ack_s;
    logic               load_s;
    logic               take_s;
    logic               win_found_s;
    logic [2:0]         win_idx_s;
    logic               int_n_r;
    logic               int_n_nxt_s;
    logic               vec_oe_r;
    logic               vec_oe_nxt_s;
    logic [7:0]         vec_dout_r;
    logic [7:0]         vec_nxt_s;
    logic [2:0]         ack_src_r;
    logic [2:0]         src_nxt_s;

    assign fall_s = irq_prev_r & ~irq_cur_r;
    assign cand_s = pending_r & irq_en;
    assign req_s  = |cand_s;
    assign ack_s  = cpu_m1 & cpu_io;
    assign load_s = (state_r == ST_IDLE) & ack_s;
    assign take_s = load_s & win_found_s;

    // Priority encoder: lowest-index enabled pending source wins.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            win_idx_s   = cand_s[i] ? 3'(i) : win_idx_s;
            win_found_s = win_found_s | cand_s[i];
        end
    end

    // Pending update: clears from ack or clr_pend, a new edge always wins.
    always_comb begin
        ack_clr_s = {NUM_SRC{1'b0}};
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            ack_clr_s[i] = take_s & (win_idx_s == 3'(i));
        end
        pending_nxt_s = (pending_r & ~(clr_pend | ack_clr_s)) | fall_s;
    end

    // Edge-detect history and pending request latches.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            irq_cur_r  <= {NUM_SRC{1'b1}};
            irq_prev_r <= {NUM_SRC{1'b1}};
            pending_r  <= {NUM_SRC{1'b0}};
        end else begin
            irq_cur_r  <= irq_n;
            irq_prev_r <= irq_cur_r;
            pending_r  <= pending_nxt_s;
        end
    end

    // Acknowledge state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: IDLE -> ACK on ack, ACK -> HOLD when ack drops, HOLD -> IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ack_s) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (ack_s) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_HOLD: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output next values; int_n is only allowed low when the FSM will be idle,
    // so the HOLD cycle always presents a deasserted request.
    always_comb begin
        vec_oe_nxt_s = (state_nxt_s == ST_ACK);
        int_n_nxt_s  = (state_nxt_s == ST_IDLE) ? ~req_s : 1'b1;
        vec_nxt_s    = load_s ? (win_found_s ? src_vec(win_idx_s) : SPUR_VEC) : vec_dout_r;
        src_nxt_s    = take_s ? win_idx_s : ack_src_r;
    end

    // Registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            int_n_r    <= 1'b1;
            vec_oe_r   <= 1'b0;
            vec_dout_r <= 8'h00;
            ack_src_r  <= 3'd0;
        end else begin
            int_n_r    <= int_n_nxt_s;
            vec_oe_r   <= vec_oe_nxt_s;
            vec_dout_r <= vec_nxt_s;
            ack_src_r  <= src_nxt_s;
        end
    end

    assign int_n    = int_n_r;
    assign vec_oe   = vec_oe_r;
    assign vec_dout = vec_dout_r;
    assign ack_src  = ack_src_r;
    assign pending  = pending_r;

endmodule

// File: tb/tb_z80_im2_irq_ctrl.sv
// Directed testbench for z80_im2_irq_ctrl with a vector scoreboard.
// A second instance with VEC_BASE=8'hFE shares all stimulus to cover the
// modulo-256 vector wrap.
module tb_z80_im2_irq_ctrl;

    typedef struct packed {
        logic [7:0] vec;
        logic [7:0] wvec;
        logic [2:0] src;
    } exp_t;

    logic       clk_sys;
    logic       reset_n;
    logic [3:0] irq_n;
    logic [3:0] irq_en;
    logic [3:0] clr_pend;
    logic       cpu_m1;
    logic       cpu_io;
    logic       int_n;
    logic [7:0] vec_dout;
    logic       vec_oe;
    logic [3:0] pending;
    logic [2:0] ack_src;
    logic       w_int_n;
    logic [7:0] w_vec_dout;
    logic       w_vec_oe;
    logic [3:0] w_pending;
    logic [2:0] w_ack_src;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    z80_im2_irq_ctrl u_dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .irq_n    (irq_n),
        .irq_en   (irq_en),
        .clr_pend (clr_pend),
        .cpu_m1   (cpu_m1),
        .cpu_io   (cpu_io),
        .int_n    (int_n),
        .vec_dout (vec_dout),
        .vec_oe   (vec_oe),
        .pending  (pending),
        .ack_src  (ack_src)
    );

    z80_im2_irq_ctrl #(.VEC_BASE(8'hFE)) u_dut_wrap (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .irq_n    (irq_n),
        .irq_en   (irq_en),
        .clr_pend (clr_pend),
        .cpu_m1   (cpu_m1),
        .cpu_io   (cpu_io),
        .int_n    (w_int_n),
        .vec_dout (w_vec_dout),
        .vec_oe   (w_vec_oe),
        .pending  (w_pending),
        .ack_src  (w_ack_src)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        checks++;
        assert (sb_q.size() > 0) else begin
            failures++;
            $error("FAIL sb_empty observed=0 expected=1");
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("vec_dout", vec_dout, e.vec);
            check("wrap_vec_dout", w_vec_dout, e.wvec);
            check("ack_src", {5'd0, ack_src}, {5'd0, e.src});
            check("wrap_ack_src", {5'd0, w_ack_src}, {5'd0, e.src});
        end
    endtask

    // Full acknowledge: ack held for 'hold' clocks, then HOLD, then back in IDLE.
    task automatic do_ack(input int hold);
        int   waited;
        exp_t head;
        head   = sb_q[0];
        cpu_m1 = 1'b1;
        cpu_io = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!vec_oe && waited < 4);
        check("ack_latency", 8'(waited), 8'd1);
        check("vec_oe_on", {7'd0, vec_oe}, 8'd1);
        pop_check();
        repeat (hold - 1) tick();
        check("vec_oe_held", {7'd0, vec_oe}, 8'd1);
        check("vec_dout_held", vec_dout, head.vec);
        cpu_m1 = 1'b0;
        cpu_io = 1'b0;
        tick();
        check("vec_oe_hold", {7'd0, vec_oe}, 8'd0);
        check("int_n_hold", {7'd0, int_n}, 8'd1);
        tick();
    endtask

    task automatic pulse_irq(input logic [3:0] low_mask);
        irq_n = ~low_mask;
        tick();
        irq_n = 4'hF;
    endtask

    initial begin
        reset_n  = 1'b0;
        irq_n    = 4'hF;
        irq_en   = 4'hF;
        clr_pend = 4'h0;
        cpu_m1   = 1'b0;
        cpu_io   = 1'b0;
        #22;
        check("rst_int_n", {7'd0, int_n}, 8'd1);
        check("rst_vec_dout", vec_dout, 8'h00);
        check("rst_vec_oe", {7'd0, vec_oe}, 8'd0);
        check("rst_pending", {4'd0, pending}, 8'h00);
        check("rst_ack_src", {5'd0, ack_src}, 8'd0);
        reset_n = 1'b1;
        tick();
        tick();

        // Single edge on source 1
        pulse_irq(4'b0010);
        check("t1_pend_early", {4'd0, pending}, 8'h00);
        tick();
        check("t1_pend", {4'd0, pending}, 8'h02);
        check("t1_int_n_early", {7'd0, int_n}, 8'd1);
        tick();
        check("t1_int_n", {7'd0, int_n}, 8'd0);
        sb_q.push_back('{vec: 8'h94, wvec: 8'h00, src: 3'd1});
        do_ack(4);
        check("t1_pend_after", {4'd0, pending}, 8'h00);
        check("t1_int_n_after", {7'd0, int_n}, 8'd1);

        // Simultaneous edges on sources 3 and 0
        pulse_irq(4'b1001);
        tick();
        tick();
        check("t2_pend", {4'd0, pending}, 8'h09);
        check("t2_int_n", {7'd0, int_n}, 8'd0);
        sb_q.push_back('{vec: 8'h92, wvec: 8'hFE, src: 3'd0});
        do_ack(2);
        check("t2_int_n_relow", {7'd0, int_n}, 8'd0);
        check("t2_pend_mid", {4'd0, pending}, 8'h08);
        sb_q.push_back('{vec: 8'h98, wvec: 8'h04, src: 3'd3});
        do_ack(2);
        check("t2_pend_after", {4'd0, pending}, 8'h00);
        check("t2_int_n_after", {7'd0, int_n}, 8'd1);

        // Disabled source latches but does not request
        irq_en = 4'b1110;
        pulse_irq(4'b0001);
        tick();
        tick();
        check("t3_pend", {4'd0, pending}, 8'h01);
        check("t3_int_n_masked", {7'd0, int_n}, 8'd1);

        // Spurious ack: nothing enabled pending
        sb_q.push_back('{vec: 8'hFF, wvec: 8'hFF, src: 3'd3});
        do_ack(2);
        check("t4_pend_kept", {4'd0, pending}, 8'h01);

        // Enabling the latched source raises the request
        irq_en = 4'hF;
        tick();
        check("t3_int_n_enabled", {7'd0, int_n}, 8'd0);
        sb_q.push_back('{vec: 8'h92, wvec: 8'hFE, src: 3'd0});
        do_ack(2);
        check("t3_pend_after", {4'd0, pending}, 8'h00);

        // New edge on source 2 lands in its own clear cycle
        pulse_irq(4'b0100);
        tick();
        tick();
        check("t5_pend", {4'd0, pending}, 8'h04);
        check("t5_int_n", {7'd0, int_n}, 8'd0);
        pulse_irq(4'b0100);
        sb_q.push_back('{vec: 8'h96, wvec: 8'h02, src: 3'd2});
        do_ack(2);
        check("t5_pend_after", {4'd0, pending}, 8'h04);
        check("t5_int_n_after", {7'd0, int_n}, 8'd0);

        // clr_pend strobe drops the request
        clr_pend = 4'b0100;
        tick();
        clr_pend = 4'h0;
        check("clr_pend", {4'd0, pending}, 8'h00);
        tick();
        check("clr_int_n", {7'd0, int_n}, 8'd1);

        // Async reset in the middle of an acknowledge
        pulse_irq(4'b1010);
        tick();
        tick();
        check("t6_pend", {4'd0, pending}, 8'h0A);
        sb_q.push_back('{vec: 8'h94, wvec: 8'h00, src: 3'd1});
        cpu_m1 = 1'b1;
        cpu_io = 1'b1;
        tick();
        check("t6_vec_oe", {7'd0, vec_oe}, 8'd1);
        pop_check();
        check("t6_pend_ack", {4'd0, pending}, 8'h08);
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_rst_vec_oe", {7'd0, vec_oe}, 8'd0);
        check("t6_rst_wrap_vec_oe", {7'd0, w_vec_oe}, 8'd0);
        check("t6_rst_int_n", {7'd0, int_n}, 8'd1);
        check("t6_rst_pend", {4'd0, pending}, 8'h00);
        check("t6_rst_wrap_pend", {4'd0, w_pending}, 8'h00);
        check("t6_rst_vec_dout", vec_dout, 8'h00);
        cpu_m1 = 1'b0;
        cpu_io = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        tick();
        check("t6_post_int_n", {7'd0, int_n}, 8'd1);
        check("t6_post_wrap_int_n", {7'd0, w_int_n}, 8'd1);
        check("t6_post_vec_oe", {7'd0, vec_oe}, 8'd0);
        check("sb_drained", 8'(sb_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
